// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   state_e         - 2-bit FSM encoding (RUN / MEM_WAIT / ERROR)
//   HZ_MEM_TIMEOUT  - default MEM_WAIT cycle limit before ERROR
//   HZ_CNT_W        - default stall-cycle counter width
//   HZ_REG_W        - register specifier width
package hazard_pkg;

    localparam int HZ_MEM_TIMEOUT = 255;
    localparam int HZ_CNT_W       = 16;
    localparam int HZ_REG_W       = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_e;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low clear
//   inc   - count this cycle
//   count - current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-flush / memory-stall control for a 5-stage pipe.
//   clk_i, rst_n_i           - clock, async active-low reset
//   IDEX_MemRead_i, IDEX_rd_i - load in EX and its destination
//   IFID_rs1_i, IFID_rs2_i    - sources of the instruction in ID
//   Branch_taken_i            - branch resolved taken in ID
//   dmem_req_i, dmem_ack_i    - MEM-stage access request / completion
//   noop_o                    - bubble into ID/EX
//   PCWrite_o, IFIDWrite_o    - PC and IF/ID write enables
//   IFIDFlush_o               - clear IF/ID to NOP
//   stall_all_o               - freeze ID/EX, EX/MEM, MEM/WB
//   err_o                     - sticky memory-timeout flag
//   stall_cnt_o               - saturating count of bubble/freeze cycles
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = HZ_MEM_TIMEOUT,
    parameter int CNT_W       = HZ_CNT_W
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                IDEX_MemRead_i,
    input  logic [HZ_REG_W-1:0] IDEX_rd_i,
    input  logic [HZ_REG_W-1:0] IFID_rs1_i,
    input  logic [HZ_REG_W-1:0] IFID_rs2_i,
    input  logic                Branch_taken_i,
    input  logic                dmem_req_i,
    input  logic                dmem_ack_i,
    output logic                noop_o,
    output logic                PCWrite_o,
    output logic                IFIDWrite_o,
    output logic                IFIDFlush_o,
    output logic                stall_all_o,
    output logic                err_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_e            r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;

    logic w_lu;
    logic w_mem_stall;
    logic w_noop, w_pcw, w_ifidw, w_flush, w_stall, w_err;

    // x0 is never written, so a load to x0 cannot create a dependency.
    assign w_lu = IDEX_MemRead_i && (IDEX_rd_i != '0) &&
                  ((IDEX_rd_i == IFID_rs1_i) || (IDEX_rd_i == IFID_rs2_i));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_mem_stall = 1'b0;
        w_noop      = 1'b0;
        w_pcw       = 1'b1;
        w_ifidw     = 1'b1;
        w_flush     = 1'b0;
        w_stall     = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            ST_RUN: begin
                // req with same-cycle ack is a single-cycle access: no stall.
                w_mem_stall = dmem_req_i && !dmem_ack_i;
                if (w_mem_stall) begin
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                // Ack releases in the same cycle and beats the timeout.
                w_mem_stall = !dmem_ack_i;
                if (dmem_ack_i) begin
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt == WAIT_MAX) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase

        // Output priority: error, memory freeze, load-use bubble, branch flush.
        if (r_state == ST_ERROR) begin
            w_err   = 1'b1;
            w_stall = 1'b1;
            w_noop  = 1'b1;
            w_pcw   = 1'b0;
            w_ifidw = 1'b0;
        end else if (w_mem_stall) begin
            w_stall = 1'b1;
            w_pcw   = 1'b0;
            w_ifidw = 1'b0;
        end else if (w_lu) begin
            w_noop  = 1'b1;
            w_pcw   = 1'b0;
            w_ifidw = 1'b0;
        end else if (Branch_taken_i) begin
            w_flush = 1'b1;
        end

        // Hold the pipe quiet while reset is asserted.
        if (!rst_n_i) begin
            w_err   = 1'b0;
            w_stall = 1'b1;
            w_noop  = 1'b1;
            w_pcw   = 1'b0;
            w_ifidw = 1'b0;
            w_flush = 1'b0;
        end
    end

    assign noop_o      = w_noop;
    assign PCWrite_o   = w_pcw;
    assign IFIDWrite_o = w_ifidw;
    assign IFIDFlush_o = w_flush;
    assign stall_all_o = w_stall;
    assign err_o       = w_err;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk_i),
        .rst_n(rst_n_i),
        .inc  (w_noop || w_stall),
        .count(stall_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed + randomized check of hazard_ctrl against a
// behavioural model (MEM_TIMEOUT=4, CNT_W=3).
module tb_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          IDEX_MemRead_i = 1'b0;
    logic [4:0]    IDEX_rd_i = '0;
    logic [4:0]    IFID_rs1_i = '0;
    logic [4:0]    IFID_rs2_i = '0;
    logic          Branch_taken_i = 1'b0;
    logic          dmem_req_i = 1'b0;
    logic          dmem_ack_i = 1'b0;
    logic          noop_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o, stall_all_o, err_o;
    logic [CW-1:0] stall_cnt_o;

    hazard_ctrl #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .IDEX_MemRead_i(IDEX_MemRead_i),
        .IDEX_rd_i     (IDEX_rd_i),
        .IFID_rs1_i    (IFID_rs1_i),
        .IFID_rs2_i    (IFID_rs2_i),
        .Branch_taken_i(Branch_taken_i),
        .dmem_req_i    (dmem_req_i),
        .dmem_ack_i    (dmem_ack_i),
        .noop_o        (noop_o),
        .PCWrite_o     (PCWrite_o),
        .IFIDWrite_o   (IFIDWrite_o),
        .IFIDFlush_o   (IFIDFlush_o),
        .stall_all_o   (stall_all_o),
        .err_o         (err_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: plain integers, no state encoding.
    bit m_waiting = 0;   // an un-acked access is outstanding
    int m_waits   = 0;   // stall cycles spent on it so far
    bit m_err     = 0;
    int m_total   = 0;
    bit e_noop, e_pcw, e_ifidw, e_flush, e_stall, e_err;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_outputs();
        bit lu, mstall;
        lu = IDEX_MemRead_i && IDEX_rd_i != 0 &&
             (IDEX_rd_i == IFID_rs1_i || IDEX_rd_i == IFID_rs2_i);
        mstall = m_waiting ? !dmem_ack_i : (dmem_req_i && !dmem_ack_i);
        {e_noop, e_pcw, e_ifidw, e_flush, e_stall, e_err} = 6'b011000;
        if (!rst_n_i)       {e_noop, e_pcw, e_ifidw, e_flush, e_stall, e_err} = 6'b100010;
        else if (m_err)     {e_noop, e_pcw, e_ifidw, e_flush, e_stall, e_err} = 6'b100011;
        else if (mstall)    {e_noop, e_pcw, e_ifidw, e_flush, e_stall, e_err} = 6'b000010;
        else if (lu)        {e_noop, e_pcw, e_ifidw, e_flush, e_stall, e_err} = 6'b100000;
        else if (Branch_taken_i) e_flush = 1'b1;
    endfunction

    // Advance the model across a rising edge using the inputs held before it.
    function automatic void model_edge();
        if (!rst_n_i) return;
        model_outputs();
        if (e_noop || e_stall) m_total = (m_total + 1 > CMAX) ? CMAX : m_total + 1;
        if (m_err) return;
        if (m_waiting) begin
            if (dmem_ack_i)        m_waiting = 0;
            else if (m_waits == TO) m_err = 1;
            else                   m_waits++;
        end else if (dmem_req_i && !dmem_ack_i) begin
            m_waiting = 1;
            m_waits   = 1;
        end
    endfunction

    // One cycle: take the edge, drive new inputs on the falling edge, check.
    task automatic step(input bit rst, input bit mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit br, input bit req, input bit ack);
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        rst_n_i = rst; IDEX_MemRead_i = mr; IDEX_rd_i = rd;
        IFID_rs1_i = rs1; IFID_rs2_i = rs2; Branch_taken_i = br;
        dmem_req_i = req; dmem_ack_i = ack;
        if (!rst) begin
            m_waiting = 0; m_waits = 0; m_err = 0; m_total = 0;
        end
        #1;
        model_outputs();
        chk("noop",      noop_o,      e_noop);
        chk("pcwrite",   PCWrite_o,   e_pcw);
        chk("ifidwrite", IFIDWrite_o, e_ifidw);
        chk("flush",     IFIDFlush_o, e_flush);
        chk("stall_all", stall_all_o, e_stall);
        chk("err",       err_o,       e_err);
        chk("stall_cnt", stall_cnt_o, m_total);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle();
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_noop", noop_o, 1);
        chk("rst_stall", stall_all_o, 1);
        chk("rst_cnt", stall_cnt_o, 0);
        idle();
        chk("run_pcw", PCWrite_o, 1);

        // Load-use: lw x5 in EX, rs1=5 in ID -> one bubble
        step(1, 1, 5, 5, 0, 0, 0, 0);
        chk("lu_noop", noop_o, 1);
        chk("lu_pcw", PCWrite_o, 0);
        idle();
        chk("lu_cnt", stall_cnt_o, 1);
        chk("lu_release", noop_o, 0);

        // Load to x0 never stalls
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("x0_noop", noop_o, 0);
        chk("x0_pcw", PCWrite_o, 1);

        // Load-use beats branch flush
        step(1, 1, 7, 3, 7, 1, 0, 0);
        chk("lubr_noop", noop_o, 1);
        chk("lubr_flush", IFIDFlush_o, 0);
        // Plain branch flush
        step(1, 0, 7, 3, 7, 1, 0, 0);
        chk("br_flush", IFIDFlush_o, 1);

        // Single-cycle access: no stall
        step(1, 0, 0, 0, 0, 0, 1, 1);
        chk("ack1_stall", stall_all_o, 0);

        // Access acked after 3 stall cycles
        do_reset();
        repeat (3) begin
            step(1, 0, 0, 0, 0, 0, 1, 0);
            chk("mw_stall", stall_all_o, 1);
        end
        step(1, 0, 0, 0, 0, 0, 1, 1);
        chk("mw_release", stall_all_o, 0);
        chk("mw_cnt", stall_cnt_o, 3);

        // Ack on the timeout cycle wins
        do_reset();
        repeat (TO) step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1);
        chk("to_ack_stall", stall_all_o, 0);
        idle();
        chk("to_ack_err", err_o, 0);

        // Timeout: error after TO+1 stall cycles, sticky until reset
        do_reset();
        repeat (TO + 1) step(1, 0, 0, 0, 0, 0, 1, 0);
        chk("to_pre_err", err_o, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1);
        chk("to_err", err_o, 1);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("to_sticky", err_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_rst_err", err_o, 0);
        idle();
        chk("to_run_pcw", PCWrite_o, 1);

        // Saturation: 10 bubbles into a 3-bit counter
        do_reset();
        repeat (10) step(1, 1, 9, 9, 0, 0, 0, 0);
        idle();
        chk("sat_cnt", stall_cnt_o, 7);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 39) != 0, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum number of MEM_WAIT cycles before the error state is entered.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 The block SHALL use one clock, clk_i (input, 1): all state updates on its rising edge.
REQ-004 rst_n_i  input  1  reset; asynchronous, active-low.
REQ-005 IDEX_MemRead_i  input  1  the instruction in EX is a load.
REQ-006 IDEX_rd_i  input  5  destination register of the instruction in EX.
REQ-007 IFID_rs1_i, IFID_rs2_i  input  5 each  source registers of the instruction in ID.
REQ-008 Branch_taken_i  input  1  a branch resolved in ID is taken.
REQ-009 dmem_req_i  input  1  the MEM stage holds a load or store.
REQ-010 dmem_ack_i  input  1  data memory completes the MEM-stage access this cycle.
REQ-011 noop_o  output  1  drives the noop_in input of the control decoder; inserts a bubble into ID/EX.
REQ-012 PCWrite_o  output  1  PC update enable.
REQ-013 IFIDWrite_o  output  1  IF/ID register write enable.
REQ-014 IFIDFlush_o  output  1  clear IF/ID to a NOP.
REQ-015 stall_all_o  output  1  freeze ID/EX, EX/MEM and MEM/WB.
REQ-016 err_o  output  1  sticky memory-timeout error flag.
REQ-017 stall_cnt_o  output  CNT_W  count of bubble or freeze cycles.

Function
REQ-018 Load-use hazard (LU) SHALL be defined as: IDEX_MemRead_i=1, IDEX_rd_i!=0, and IDEX_rd_i equals IFID_rs1_i or IFID_rs2_i.
REQ-019 FSM states SHALL be RUN, MEM_WAIT and ERROR; all outputs except the counters SHALL be combinational from the state and the inputs.
REQ-020 RUN, dmem_req_i=1 and dmem_ack_i=0: stall_all_o=1, PCWrite_o=0, IFIDWrite_o=0, noop_o=0, IFIDFlush_o=0; next state MEM_WAIT; wait counter loaded with 1.
REQ-021 RUN, no memory stall, LU=1: noop_o=1, PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0, regardless of Branch_taken_i.
REQ-022 RUN, no memory stall, LU=0, Branch_taken_i=1: IFIDFlush_o=1, PCWrite_o=1, IFIDWrite_o=1, noop_o=0.
REQ-023 RUN, otherwise: PCWrite_o=1, IFIDWrite_o=1, and all other outputs 0.
REQ-024 Priority SHALL be memory stall over LU over branch flush.
REQ-025 MEM_WAIT, dmem_ack_i=0: freeze outputs as in REQ-020; wait counter increments by 1.
REQ-026 MEM_WAIT, dmem_ack_i=1: RUN output rules apply in the same cycle (zero-cycle release); next state RUN.
REQ-027 MEM_WAIT, wait counter = MEM_TIMEOUT and dmem_ack_i=0: next state ERROR.
REQ-028 MEM_WAIT, ack arrives in the same cycle the counter reaches MEM_TIMEOUT: the ack SHALL win and the next state is RUN.
REQ-029 ERROR: err_o=1, stall_all_o=1, PCWrite_o=0, IFIDWrite_o=0, noop_o=1; the block SHALL leave ERROR only through reset.
REQ-030 stall_cnt_o SHALL increment on every clock edge where noop_o or stall_all_o is 1, and SHALL saturate at 2^CNT_W-1.
REQ-031 An ack while in RUN with dmem_req_i=1 is a single-cycle access and SHALL cause no stall.

Reset
REQ-032 While rst_n_i=0: state=RUN, wait counter=0, stall_cnt_o=0, err_o=0.
REQ-033 While rst_n_i=0: noop_o=1, stall_all_o=1, PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0.
REQ-034 Reset asserted in MEM_WAIT or ERROR SHALL return the block to RUN immediately, without waiting for a clock edge.
REQ-035 Deassertion of rst_n_i SHALL be synchronized externally; the first edge after release is normal RUN operation.

Structure
REQ-036 Package hazard_pkg SHALL hold the state encoding (2 bits) and the default values of MEM_TIMEOUT and CNT_W.
REQ-037 The saturating stall counter SHALL be a sub-module, sat_counter (parameter W; ports: clk, rst_n, inc, count).
REQ-038 The FSM and the LU compare SHALL reside in hazard_ctrl.

Verification
REQ-039 Load-use: EX=lw x5, ID rs1=5 -> exactly 1 cycle with noop_o=1 and PCWrite_o=0; stall_cnt_o=1.
REQ-040 Load to x0: IDEX_rd_i=0, rs1=0, MemRead=1 -> no stall.
REQ-041 Load-use together with Branch_taken_i=1 -> noop_o=1 and IFIDFlush_o=0.
REQ-042 dmem_req_i=1 and ack after 3 cycles -> stall_all_o high for 3 cycles, released in the ack cycle; stall_cnt_o=3.
REQ-043 MEM_TIMEOUT=4 and ack never arrives -> err_o=1 after 5 stall cycles; err_o remains 1 until rst_n_i is pulsed low, then RUN.
REQ-044 Saturation: CNT_W=3 with 10 stall cycles -> stall_cnt_o=7.
